// File: rtl/delay_analog_pkg.sv
// Shared helpers for the delay_analog real-valued delay line.
// DELAY_ANALOG_SAT_EN selects saturation instead of wrap on format overflow.
package delay_analog_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int ptr_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic longint smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic longint fit(input longint v, input int w);
`ifdef DELAY_ANALOG_SAT_EN
    if (v > smax(w)) return smax(w);
    if (v < smin(w)) return smin(w);
    return v;
`else
    logic [63:0] hi;
    hi = {64{1'b1}} << w;
    return v[w-1] ? (v | longint'(hi)) : (v & ~longint'(hi));
`endif
  endfunction

  function automatic longint align(
    input longint v,
    input int     d,
    input int     w
  );
    longint s;
    s = (d >= 0) ? (v <<< d) : (v >>> (-d));
    return fit(s, w);
  endfunction

  // Round half away from zero onto the output LSB grid.
  function automatic longint real_code(input real x, input int e);
    real s;
    real y;
    s = 1.0;
    if (e < 0) repeat (-e) s = s * 2.0;
    else repeat (e) s = s / 2.0;
    y = x * s;
    if (y >= 0.0) return longint'($rtoi(y + 0.5));
    return -longint'($rtoi(-y + 0.5));
  endfunction

endpackage

// File: rtl/delay_analog_if.sv
// Sample/tap/output bundle between a producer and delay_analog.
// DELAY_ANALOG_SAT_EN does not change this interface.
interface delay_analog_if
  import delay_analog_pkg::*;
#(
  parameter int width_in  = 16,
  parameter int width_out = 16,
  parameter int depth     = 8
);
  localparam int TW = clog2(depth + 1);

  logic                        cke;
  logic signed [width_in-1:0]  in;
  logic [TW-1:0]               tap;
  logic signed [width_out-1:0] out;
  logic                        out_valid;

  modport master (
    output cke, in, tap,
    input  out, out_valid
  );

  modport slave (
    input  cke, in, tap,
    output out, out_valid
  );
endinterface

// File: rtl/delay_analog_align_real.sv
// Combinational fixed-point format conversion: shift, then fit.
// DELAY_ANALOG_SAT_EN clamps on overflow; otherwise low bits are kept.
module align_real
  import delay_analog_pkg::*;
#(
  parameter int WI = 16,
  parameter int EI = -8,
  parameter int WO = 16,
  parameter int EO = -8
) (
  input  logic signed [WI-1:0] in_i,
  output logic signed [WO-1:0] out_o
);
  localparam int D  = EI - EO;
  localparam int LS = (D > 0) ? D : 0;
  localparam int RS = (D < 0) ? -D : 0;
  localparam int W  = ((WI + LS > WO) ? WI + LS : WO) + 1;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] shf;

  always_comb begin
    ext = W'(in_i);
    shf = (ext <<< LS) >>> RS;
  end

`ifdef DELAY_ANALOG_SAT_EN
  localparam logic signed [W-1:0] MAXV = W'(smax(WO));
  localparam logic signed [W-1:0] MINV = W'(smin(WO));

  always_comb begin
    out_o = WO'(shf);
    if (shf > MAXV) out_o = WO'(MAXV);
    else if (shf < MINV) out_o = WO'(MINV);
  end
`else
  logic unused_hi;

  assign unused_hi = ^shf[W-1:WO];
  assign out_o     = WO'(shf);
`endif
endmodule

// File: rtl/delay_analog.sv
// Fixed-point delay line with runtime tap ahead of an analog memory.
// DELAY_ANALOG_SAT_EN selects saturating format conversion.
module delay_analog
  import delay_analog_pkg::*;
#(
  parameter int  width_in     = 16,
  parameter int  exponent_in  = -8,
  parameter int  width_out    = 16,
  parameter int  exponent_out = -8,
  parameter int  depth        = 8,
  parameter real init         = 0.0
) (
  input logic          clk,
  input logic          rst,
  delay_analog_if.slave bus
);
  localparam int PW = ptr_w(depth);
  localparam int TW = clog2(depth + 1);
  localparam int AW = TW + 1;

  localparam logic signed [width_out-1:0] INIT_CODE =
    width_out'(fit(real_code(init, exponent_out), width_out));

  logic signed [width_out-1:0] ain;
  logic signed [width_out-1:0] mem_q [depth];

  logic [PW-1:0]               wp_q,  wp_d;
  logic [TW-1:0]               cnt_q, cnt_d;
  logic signed [width_out-1:0] out_q, out_d;
  logic                        vld_q, vld_d;
  logic [TW-1:0]               t;
  logic [AW-1:0]               rd_sum;
  logic [PW-1:0]               rd_idx;

  align_real #(
    .WI (width_in),
    .EI (exponent_in),
    .WO (width_out),
    .EO (exponent_out)
  ) u_align (
    .in_i  (bus.in),
    .out_o (ain)
  );

  // Read slot is (wp - t) mod depth without a true modulo.
  always_comb begin
    t      = (bus.tap > TW'(depth)) ? TW'(depth) : bus.tap;
    rd_sum = AW'(wp_q) + AW'(depth) - AW'(t);
    if (rd_sum >= AW'(depth)) rd_sum = rd_sum - AW'(depth);
    rd_idx = PW'(rd_sum);
  end

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    out_d = out_q;
    vld_d = vld_q;
    if (bus.cke) begin
      wp_d  = (wp_q == PW'(depth - 1)) ? '0 : wp_q + 1'b1;
      cnt_d = (cnt_q == TW'(depth)) ? cnt_q : cnt_q + 1'b1;
      if (t == '0) begin
        out_d = ain;
        vld_d = 1'b1;
      end else if (t <= cnt_q) begin
        out_d = mem_q[rd_idx];
        vld_d = 1'b1;
      end else begin
        out_d = INIT_CODE;
        vld_d = 1'b0;
      end
    end
  end

  // Contents are left unreset; cnt_q keeps stale slots from being read.
  always_ff @(posedge clk) begin
    if (bus.cke) mem_q[wp_q] <= ain;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
      out_q <= INIT_CODE;
      vld_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_delay_analog.sv
// Scoreboard bench for delay_analog: three format variants, one stimulus.
// Expected values come from a sample-history model of the delay line.
module tb_delay_analog;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  delay_analog_if #(.width_in(16), .width_out(16), .depth(8)) ifa ();
  delay_analog_if #(.width_in(16), .width_out(12), .depth(4)) ifb ();
  delay_analog_if #(.width_in(16), .width_out(16), .depth(2)) ifc ();

  delay_analog #(
    .width_in(16), .exponent_in(-8), .width_out(16),
    .exponent_out(-8), .depth(8), .init(0.0)
  ) u_a (.clk(clk), .rst(rst), .bus(ifa));

  delay_analog #(
    .width_in(16), .exponent_in(-4), .width_out(12),
    .exponent_out(-8), .depth(4), .init(-1.5)
  ) u_b (.clk(clk), .rst(rst), .bus(ifb));

  delay_analog #(
    .width_in(16), .exponent_in(-10), .width_out(16),
    .exponent_out(-8), .depth(2), .init(0.5)
  ) u_c (.clk(clk), .rst(rst), .bus(ifc));

  int dep [3] = '{8, 4, 2};
  int ein [3] = '{-8, -4, -10};
  int wout[3] = '{16, 12, 16};
  int tapw[3] = '{4, 3, 2};
  longint icode[3] = '{0, -384, 128};

  typedef struct {
    longint o;
    bit     v;
  } exp_t;

  exp_t   expq [3][$];
  longint hist [3][$];
  exp_t   last [3];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic longint ref_align(longint v, int ei, int wo);
    longint r, p, lim, m;
    int d;
    d = ei - (-8);
    if (d >= 0) r = v * (longint'(1) << d);
    else begin
      p = longint'(1) << (-d);
      r = v / p;
      if ((v % p != 0) && (v < 0)) r = r - 1;
    end
    lim = longint'(1) << (wo - 1);
`ifdef DELAY_ANALOG_SAT_EN
    if (r >= lim) r = lim - 1;
    else if (r < -lim) r = -lim;
`else
    m = 2 * lim;
    r = r % m;
    if (r < 0) r = r + m;
    if (r >= lim) r = r - m;
`endif
    return r;
  endfunction

  function automatic longint act_out(int k);
    if (k == 0) return longint'(ifa.out);
    if (k == 1) return longint'(ifb.out);
    return longint'(ifc.out);
  endfunction

  function automatic bit act_vld(int k);
    if (k == 0) return ifa.out_valid;
    if (k == 1) return ifb.out_valid;
    return ifc.out_valid;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (expq[k].size() > 0) begin
        exp_t e;
        e = expq[k].pop_front();
        n_tests++;
        if (act_out(k) !== e.o || act_vld(k) !== e.v) begin
          n_fail++;
          $display("FAIL sb dut%0d @%0t: out=%0d vld=%0b expected out=%0d vld=%0b",
                   k, $time, act_out(k), act_vld(k), e.o, e.v);
        end
      end
    end
  end

  task automatic step(bit c, longint x, int tp);
    ifa.cke = c; ifb.cke = c; ifc.cke = c;
    ifa.in = 16'(x); ifb.in = 16'(x); ifc.in = 16'(x);
    ifa.tap = 4'(tp); ifb.tap = 3'(tp); ifc.tap = 2'(tp);
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      int t;
      longint a;
      e = last[k];
      if (c) begin
        t = tp & ((1 << tapw[k]) - 1);
        if (t > dep[k]) t = dep[k];
        a = ref_align(longint'($signed(16'(x))), ein[k], wout[k]);
        if (t == 0) begin
          e.o = a; e.v = 1'b1;
        end else if (t <= hist[k].size()) begin
          e.o = hist[k][hist[k].size() - t]; e.v = 1'b1;
        end else begin
          e.o = icode[k]; e.v = 1'b0;
        end
        hist[k].push_back(a);
        if (hist[k].size() > dep[k]) void'(hist[k].pop_front());
      end
      last[k] = e;
      expq[k].push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out%0d", k), act_out(k), icode[k]);
      chk($sformatf("rst_vld%0d", k), longint'(act_vld(k)), 0);
      hist[k].delete();
      last[k].o = icode[k];
      last[k].v = 1'b0;
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic signed [15:0] r;
    ifa.cke = 0; ifb.cke = 0; ifc.cke = 0;
    ifa.in = 0; ifb.in = 0; ifc.in = 0;
    ifa.tap = 0; ifb.tap = 0; ifc.tap = 0;
    #1;
    do_reset();
    @(posedge clk);
    #2;

    step(1, 'h100, 3);
    step(1, 'h200, 3);
    step(1, 'h300, 3);
    chk("basic_vld3", longint'(ifa.out_valid), 0);
    chk("basic_out3", longint'(ifa.out), 0);
    step(1, 'h400, 3);
    chk("basic_out4", longint'(ifa.out), 'h100);
    chk("basic_vld4", longint'(ifa.out_valid), 1);

    for (int tp = 8; tp <= 9; tp++) begin
      do_reset();
      for (int i = 1; i <= 12; i++) begin
        step(1, i, tp);
        if (i == 9) chk($sformatf("max_tap%0d_e9", tp), longint'(ifa.out), 1);
        if (i == 12) chk($sformatf("max_tap%0d_e12", tp), longint'(ifa.out), 4);
      end
    end

    do_reset();
    step(1, 'h100, 0);
    chk("fmt_b_vld", longint'(ifb.out_valid), 1);
`ifdef DELAY_ANALOG_SAT_EN
    chk("fmt_b_sat", longint'(ifb.out), 2047);
`else
    chk("fmt_b_wrap", longint'(ifb.out), 0);
`endif
    step(1, -3, 0);
    chk("fmt_c_floor", longint'(ifc.out), -1);

    for (int i = 0; i < 10; i++) step(1, i * 37 - 100, 3);
    for (int i = 0; i < 5; i++) step(0, $urandom, $urandom_range(0, 9));
    for (int i = 0; i < 6; i++) step(1, i + 50, 3);

    for (int i = 0; i < 10; i++) step(1, i * 11, 5);
    #2;
    do_reset();
    step(1, 7, 2);
    chk("post_rst_e1", longint'(ifa.out_valid), 0);
    step(1, 8, 2);
    chk("post_rst_e2", longint'(ifa.out_valid), 0);
    step(1, 9, 2);
    chk("post_rst_e3", longint'(ifa.out), 7);

    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      step($urandom_range(0, 9) < 8, longint'(r), $urandom_range(0, 10));
      if (i == 200) begin
        #2;
        do_reset();
      end
    end

    @(posedge clk);
    #3;
    for (int k = 0; k < 3; k++)
      chk($sformatf("drain%0d", k), expq[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
